data_bus_router: RTL

// - Routes the core data port (CORE_DATA_INF_M2S/S2M) to N_SLAVES targets by address:

---
 rtl/data_bus_router_pkg.sv | 52 +++++
 rtl/data_bus_router_if.sv | 21 ++
 rtl/data_bus_router_resp_fifo.sv | 65 ++++++
 rtl/data_bus_router.sv | 123 ++++++++++++
 4 files changed

// File: rtl/data_bus_router_pkg.sv
// Shared types and default address map for the core data-port router.
// Slot 0 inst RAM loader path, slot 1 data memory, slot 2 peripherals.
package data_bus_router_pkg;

  localparam int N_SLAVES_DEF = 3;
  localparam int MAX_OUT_DEF  = 2;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef logic [31:0] addr_map_t [N_SLAVES_DEF];

  localparam addr_map_t DEF_BASE = '{
    32'h0000_0000,
    32'h1000_0000,
    32'h2000_0000
  };

  localparam addr_map_t DEF_MASK = '{
    default: 32'hFFFF_E000
  };

  typedef logic [$clog2(N_SLAVES_DEF)-1:0] slv_idx_t;

  typedef struct packed {
    slv_idx_t idx;
    logic     is_write;
    logic     is_err;
  } resp_entry_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_m2s_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } bus_s2m_t;

  function automatic logic addr_hit(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] mask
  );
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/data_bus_router_if.sv
// Data bus bundle: N request/response lanes sharing one handshake.
// The master side issues requests, the slave side answers them.
interface data_bus_router_if #(
  parameter int N = 1
);
  import data_bus_router_pkg::*;

  bus_m2s_t [N-1:0] m2s;
  bus_s2m_t [N-1:0] s2m;

  modport master (
    output m2s,
    input  s2m
  );

  modport slave (
    input  m2s,
    output s2m
  );

endinterface

// File: rtl/data_bus_router_resp_fifo.sv
// In-order tracker of accepted transactions awaiting their response.
// Head is always visible; push and pop may coincide.
module bus_resp_fifo
  import data_bus_router_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = resp_entry_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_router.sv
// Routes the core data port to N targets by address and returns
// responses in issue order; writes and unmapped accesses finish locally.
module data_bus_router
  import data_bus_router_pkg::*;
#(
  parameter int          N_SLAVES                  = N_SLAVES_DEF,
  parameter int          MAX_OUTSTANDING           = MAX_OUT_DEF,
  parameter logic [31:0] SLAVE_BASE [N_SLAVES]     = DEF_BASE,
  parameter logic [31:0] SLAVE_MASK [N_SLAVES]     = DEF_MASK,
  parameter logic [31:0] ERR_RDATA                 = ERR_RDATA_DEF,
  localparam int         CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  data_bus_router_if.slave  core_bus,
  data_bus_router_if.master slv_bus,
  output logic              bus_err_o
);

  bus_m2s_t      core_req;
  slv_idx_t      dec_idx;
  logic          mapped;
  logic          core_gnt;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;
  resp_entry_t   push_entry;
  resp_entry_t   head;
  logic          head_rd;
  logic          head_loc;
  logic          head_slv_rv;
  logic          core_rvalid;
  logic [31:0]   core_rdata;

  assign core_req = core_bus.m2s[0];

  // Address decode: scan high to low so the lowest matching slot wins.
  always_comb begin
    mapped  = 1'b0;
    dec_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (addr_hit(core_req.addr, SLAVE_BASE[i], SLAVE_MASK[i])) begin
        mapped  = 1'b1;
        dec_idx = slv_idx_t'(i);
      end
    end
  end

  // Broadcast the request payload; req only to the decoded slot with room.
  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      slv_bus.m2s[i]     = core_req;
      slv_bus.m2s[i].req = core_req.req && mapped && !full && rst_ni &&
                           (dec_idx == slv_idx_t'(i));
    end
  end

  // Grant comes from the target, or immediately for an unmapped address.
  always_comb begin
    core_gnt = 1'b0;
    if (core_req.req && !full && rst_ni) begin
      core_gnt = mapped ? slv_bus.s2m[dec_idx].gnt : 1'b1;
    end
  end

  assign push       = core_req.req && core_gnt;
  assign push_entry = '{idx: dec_idx, is_write: core_req.we, is_err: !mapped};

  bus_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (resp_entry_t)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .din    (push_entry),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  // Head completion: local entries finish at once, reads wait for their slave.
  always_comb begin
    head_loc    = !empty && (head.is_write || head.is_err);
    head_rd     = !empty && !head.is_write && !head.is_err;
    head_slv_rv = head_rd && slv_bus.s2m[head.idx].rvalid;
    core_rvalid = head_loc || head_slv_rv;
    core_rdata  = '0;
    if (head_slv_rv) begin
      core_rdata = slv_bus.s2m[head.idx].rdata;
    end else if (head_loc && head.is_err && !head.is_write) begin
      core_rdata = ERR_RDATA;
    end
  end

  assign pop       = core_rvalid;
  assign bus_err_o = head_loc && head.is_err;

  // Response bundle back to the core.
  always_comb begin
    core_bus.s2m[0]        = '0;
    core_bus.s2m[0].gnt    = core_gnt;
    core_bus.s2m[0].rvalid = core_rvalid;
    core_bus.s2m[0].rdata  = core_rdata;
  end

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_sva
    a_rvalid_from_head: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (slv_bus.s2m[g].rvalid && head_rd) |-> (head.idx == slv_idx_t'(g))
    );
  end

  a_count_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    fifo_count <= CW'(MAX_OUTSTANDING)
  );

endmodule
